// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the hazard/sequencing controller:
// forwarding-select codes, the load encoding of ResultSrc, and the
// multiply/divide sequencer state type.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from ALUResultM

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Multiply/divide sequencer: launches the unit on the first Execute cycle
// of a mul/div op and holds the pipeline front until the result pulse.
// Present only when MULDIV_EN is defined.
`ifdef MULDIV_EN
module md_seq
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mul_div,
  input  logic md_done,
  output logic md_start,
  output logic md_busy,
  output logic md_stall
);

  md_state_t state, state_next;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, start pulse and stall request.
  always_comb begin
    state_next = state;
    md_start   = 1'b0;
    md_stall   = 1'b0;
    unique case (state)
      IDLE: begin
        // md_done here is a stray pulse and is ignored.
        if (mul_div) begin
          md_start   = 1'b1;
          md_stall   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Stall drops in the done cycle so the result advances at the
        // next edge and the following op enters Execute in IDLE.
        if (md_done) state_next = IDLE;
        else         md_stall   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign md_busy = (state == BUSY);

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage RV32 core: execute-stage
// forwarding selects, load-use stall, control-transfer flush, and the
// optional multiply/divide sequencer (compiled in with MULDIV_EN).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RDE,
  input  logic [4:0] RDM,
  input  logic [4:0] RDW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MulDivE,
  input  logic       MdDone,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MdStart,
  output logic       MdBusy
);

  logic lw_stall;
  logic md_stall;

  // Operand forwarding; the younger Memory-stage result wins over Writeback.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RegWriteM && (RDM != 5'd0) && (RDM == Rs1E))      ForwardAE = FWD_M;
    else if (RegWriteW && (RDW != 5'd0) && (RDW == Rs1E)) ForwardAE = FWD_W;
    if (RegWriteM && (RDM != 5'd0) && (RDM == Rs2E))      ForwardBE = FWD_M;
    else if (RegWriteW && (RDW != 5'd0) && (RDW == Rs2E)) ForwardBE = FWD_W;
  end

  assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RDE != 5'd0) &&
                    ((RDE == Rs1D) || (RDE == Rs2D));

`ifdef MULDIV_EN
  md_seq u_md_seq (
    .clk      (clk),
    .reset    (reset),
    .mul_div  (MulDivE),
    .md_done  (MdDone),
    .md_start (MdStart),
    .md_busy  (MdBusy),
    .md_stall (md_stall)
  );
`else
  // No sequencer: mul/div ops flow through Execute like any other op.
  logic unused_md;
  assign unused_md = ^{clk, reset, MulDivE, MdDone};
  assign md_stall  = 1'b0;
  assign MdStart   = 1'b0;
  assign MdBusy    = 1'b0;
`endif

  // Stall/flush combination; the load-use bubble is only injected into
  // ID-EX while Execute is advancing, otherwise it would erase the held op.
  always_comb begin
    StallF = lw_stall || md_stall;
    StallD = lw_stall || md_stall;
    StallE = md_stall;
    FlushD = PCSrcE;
    FlushE = (lw_stall && !md_stall) || PCSrcE;
    FlushM = md_stall;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RV32 core. It generates the execute-stage forwarding selects, the load-use stall, and the control-transfer flush. It also sequences a multi-cycle multiply/divide unit attached beside the execute-stage ALU, holding the front of the pipeline while that unit is busy. It sits beside the pipeline registers and drives their stall/flush controls.

## Interface
- No parameters.
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- Rs1D, Rs2D  input  5  source registers of instruction in Decode
- Rs1E, Rs2E  input  5  source registers of instruction in Execute
- RDE, RDM, RDW  input  5  destination registers in Execute / Memory / Writeback
- RegWriteM, RegWriteW  input  1  register-write enables in Memory / Writeback
- ResultSrcE  input  2  result select in Execute; 2'b01 = load
- PCSrcE  input  1  taken branch/jump resolved in Execute
- MulDivE  input  1  instruction in Execute is a multiply/divide op
- MdDone  input  1  multiply/divide unit result valid, single-cycle pulse
- ForwardAE, ForwardBE  output  2  operand selects: 00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE  output  1  hold PC / IF-ID / ID-EX registers
- FlushD, FlushE, FlushM  output  1  clear IF-ID / ID-EX / EX-MEM registers to a bubble
- MdStart  output  1  start pulse to the multiply/divide unit
- MdBusy  output  1  sequencer in BUSY

## Operation
- Forwarding (combinational): ForwardAE = 10 if RegWriteM && RDM!=0 && RDM==Rs1E; else 01 if RegWriteW && RDW!=0 && RDW==Rs1E; else 00. ForwardBE is the same using Rs2E. Memory stage has priority over Writeback.
- Load-use: lwStall = (ResultSrcE==01) && RDE!=0 && (RDE==Rs1D || RDE==Rs2D).
- Sequencer FSM, states IDLE and BUSY:
  - IDLE with MulDivE=1: MdStart=1, next state BUSY.
  - BUSY: remains until MdDone=1, then next state IDLE.
  - MdDone while in IDLE is ignored.
- mdStall = (IDLE && MulDivE) || (BUSY && !MdDone).
- StallF = StallD = lwStall || mdStall. StallE = mdStall.
- FlushD = PCSrcE.
- FlushE = (lwStall && !mdStall) || PCSrcE. This injects the load-use bubble only when Execute is advancing.
- FlushM = mdStall. Memory receives bubbles while the op is held in Execute.
- In BUSY with MdDone=1, all md stalls drop in that same cycle. The result is captured into EX-MEM at the next edge, and the following instruction enters Execute in IDLE, so the op is never restarted.
- PCSrcE and MulDivE cannot be asserted by the same instruction. If both are seen, PCSrcE flushes are still driven and the sequencer behaves as specified.
- MdBusy = (state==BUSY).

## Timing
- Reset (asynchronous): state goes to IDLE immediately. MdStart=0, MdBusy=0.
- Stall/flush outputs follow the combinational equations with state=IDLE. With all-zero inputs, every output is 0.
- MdStart is a 1-cycle pulse in the first Execute cycle of a mul/div op.
- Minimum mul/div occupancy is 2 cycles: the start cycle plus a BUSY cycle with MdDone.
- Reset asserted mid-BUSY aborts the op. The multiply/divide unit shares the same reset.
- Forwarding and stall paths are purely combinational; only the FSM state is registered.

## Configuration
- MULDIV_EN defined: sequencer, MdStart, and MdBusy are compiled in as above.
- MULDIV_EN undefined: no FSM is present. MdStart=0, MdBusy=0, mdStall=0, and MulDivE/MdDone are ignored. Stalls and flushes reduce to the load-use and branch terms.

## Structure
- The shared core package holds:
  - forward-select constants (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10)
  - the ResultSrc load encoding
  - the md_state_t enum (IDLE, BUSY)
- Sub-module md_seq contains the FSM, MdStart, MdBusy, and mdStall. It is instantiated only under MULDIV_EN.

## Test plan
- Rs1E=5, RDM=5, RegWriteM=1, RDW=5, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. RDM=RDW=0 -> ForwardAE=00.
- ResultSrcE=01, RDE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0. RDE=0 -> no stall.
- PCSrcE=1 together with the load-use case -> FlushD=1, FlushE=1, StallF=1.
- MulDivE=1 from IDLE -> MdStart=1 for one cycle, StallF/D/E=1, FlushM=1. MdDone after 3 BUSY cycles -> stalls drop on the MdDone cycle and state returns to IDLE. The next op gets a new MdStart.
- Load-use hazard in Decode while BUSY -> FlushE=0 until MdDone. The load-use bubble is inserted on the following cycle.
- Reset pulse mid-BUSY -> MdBusy=0 and the stalls drop asynchronously. Build without MULDIV_EN: MulDivE=1 produces no stall and MdStart stays 0.
